control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter OPCODE_W, default 8, opcode width; values above 8 are zero-extended on compare.
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready (1..255).
REQ-004 SHALL have parameter ILLEGAL_HALTS, default 1: 1 = illegal opcode halts, 0 = treated as NOP.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-008 SHALL have port opcode  input  OPCODE_W  opcode of the fetched instruction; sampled only in DECODE.
REQ-009 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-010 SHALL have port mem_req  output  1  memory request active.
REQ-011 SHALL have port ir_load  output  1  load instruction register.
REQ-012 SHALL have port pc_enable  output  1  advance PC (PC+1, or jump target when jump_enable).
REQ-013 SHALL have ports write_enable_memory, write_enable_reg, jump_enable, finaliza_execucao  output  1 each  store enable, register write enable, jump select, execution finished.
REQ-014 SHALL have port control_op  output  2  register write source: 00 ALU, 01 sign-extend, 10 reg2, 11 memory.
REQ-015 SHALL have ports illegal_op, bus_error  output  1 each  sticky fault flags.
REQ-016 SHALL have port instr_count  output  CNT_W  retired instructions, saturating.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs SHALL be decoded from state, latched opcode and mem_ready only.
REQ-018 IDLE: all outputs 0; start=1 -> FETCH next cycle.
REQ-019 FETCH: mem_req=1; on mem_ready, ir_load=1 that cycle -> DECODE.
REQ-020 DECODE: opcode latched into internal register; 0xFF -> HALT; illegal (not 00,01,02,03,05,09,0A,0B,0C,FF) sets illegal_op -> HALT if ILLEGAL_HALTS=1, else pc_enable=1, retire -> FETCH; other legal -> EXEC.
REQ-021 EXEC, one cycle: 00 -> write_enable_reg=1, control_op=01; 01 -> write_enable_reg=1, control_op=10; 09/0A/0B/0C -> write_enable_reg=1, control_op=00; each with pc_enable=1 -> FETCH.
REQ-022 EXEC for 05: jump_enable=1, pc_enable=1, write enables 0 -> FETCH.
REQ-023 EXEC for 02/03: no strobes -> MEM.
REQ-024 MEM: mem_req=1; store holds write_enable_memory=1 every MEM cycle; on mem_ready a store asserts pc_enable=1 -> FETCH; a load -> WB.
REQ-025 WB: write_enable_reg=1, control_op=11, pc_enable=1 -> FETCH.
REQ-026 A wait counter SHALL clear on entering FETCH or MEM and increment each cycle without mem_ready; reaching MEM_TIMEOUT with mem_ready low sets bus_error -> HALT.
REQ-027 mem_ready in the timeout cycle SHALL win: transaction completes, no bus_error.
REQ-028 HALT: finaliza_execucao=1 held, all strobes 0, start ignored, exit only by rst.
REQ-029 instr_count SHALL increment by 1 in each cycle pc_enable=1, saturate at 2^CNT_W-1; HALT opcode not counted.
REQ-030 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-031 rst=1 at a clock edge, in any state including mid-MEM, SHALL force IDLE, clear opcode latch, wait counter, instr_count, illegal_op, bus_error; all outputs 0 the following cycle.
REQ-032 rst SHALL take priority over start and mem_ready in the same cycle.

Verification
REQ-033 Reset, start=1, opcode 09, mem_ready=1 always -> FETCH,DECODE,EXEC; write_enable_reg=1, control_op=00, pc_enable=1 in cycle 3; instr_count=1.
REQ-034 Load 02, mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB with control_op=11, write_enable_reg=1; no bus_error.
REQ-035 Store 03, mem_ready never -> write_enable_memory=1 for 15 cycles, bus_error=1, HALT, finaliza_execucao=1.
REQ-036 Opcode 0x77, ILLEGAL_HALTS=1 -> illegal_op=1, HALT; with ILLEGAL_HALTS=0 -> pc_enable=1, back to FETCH, instr_count+1.
REQ-037 Opcode FF -> HALT; start pulses ignored; rst -> IDLE, instr_count=0.
REQ-038 CNT_W=2, 5 ALU ops -> instr_count saturates at 3.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm -- instruction-sequencing controller for a small multicycle CPU.
//
// The controller walks each instruction through FETCH -> DECODE -> EXEC and,
// for loads and stores, through MEM and WB. Every memory wait is bounded, so a
// request that is never acknowledged ends in HALT with a sticky bus error. An
// unknown opcode sets a sticky illegal flag and either halts or is retired as
// a NOP, depending on ILLEGAL_HALTS. Strobes are decoded combinationally from
// the current state, the latched opcode and mem_ready. The one exception is
// DECODE, where the incoming opcode is the value being latched.
//
// Parameters
//   OPCODE_W      opcode width; opcodes narrower than 8 bits are zero-extended
//                 before they are compared with the 8-bit opcode constants.
//   CNT_W         width of the saturating retired-instruction counter
//   MEM_TIMEOUT   maximum number of cycles to wait for mem_ready (1..255)
//   ILLEGAL_HALTS 1: an illegal opcode halts, 0: it is retired as a NOP
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset
//   start               leave IDLE and begin fetching
//   opcode              opcode of the fetched instruction, sampled in DECODE
//   mem_ready           memory completes the current request this cycle
//   mem_req             memory request active (FETCH, MEM)
//   ir_load             load the instruction register
//   pc_enable           advance the PC (PC+1, or the jump target if jump_enable)
//   write_enable_memory store enable, held for every MEM cycle of a store
//   write_enable_reg    register-file write enable
//   jump_enable         select the jump target for the PC
//   finaliza_execucao   execution finished (HALT)
//   control_op          register write source: 00 ALU, 01 sext, 10 reg2, 11 mem
//   illegal_op          sticky: an illegal opcode was decoded
//   bus_error           sticky: a memory wait timed out
//   instr_count         retired instructions, saturating

module control_fsm #(
  parameter int OPCODE_W      = 8,
  parameter int CNT_W         = 16,
  parameter int MEM_TIMEOUT   = 15,
  parameter int ILLEGAL_HALTS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                write_enable_memory,
  output logic                write_enable_reg,
  output logic                jump_enable,
  output logic                finaliza_execucao,
  output logic [1:0]          control_op,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [CNT_W-1:0]    instr_count
);

  // Opcodes are compared at the wider of OPCODE_W and 8 bits. This keeps the
  // comparisons correct whether the opcode is wider or narrower than 8 bits.
  localparam int CMP_W = (OPCODE_W > 8) ? OPCODE_W : 8;

  localparam logic [CMP_W-1:0] OP_SEXT  = CMP_W'(8'h00);
  localparam logic [CMP_W-1:0] OP_MOV   = CMP_W'(8'h01);
  localparam logic [CMP_W-1:0] OP_LOAD  = CMP_W'(8'h02);
  localparam logic [CMP_W-1:0] OP_STORE = CMP_W'(8'h03);
  localparam logic [CMP_W-1:0] OP_JUMP  = CMP_W'(8'h05);
  localparam logic [CMP_W-1:0] OP_ALU0  = CMP_W'(8'h09);
  localparam logic [CMP_W-1:0] OP_ALU1  = CMP_W'(8'h0A);
  localparam logic [CMP_W-1:0] OP_ALU2  = CMP_W'(8'h0B);
  localparam logic [CMP_W-1:0] OP_ALU3  = CMP_W'(8'h0C);
  localparam logic [CMP_W-1:0] OP_HALT  = CMP_W'(8'hFF);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_SEXT = 2'b01;
  localparam logic [1:0] SRC_REG2 = 2'b10;
  localparam logic [1:0] SRC_MEM  = 2'b11;

  // The wait counter holds 0..MEM_TIMEOUT-1. The last permitted wait cycle is
  // the one in which the counter already shows MEM_TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [7:0]            wait_q, wait_d;
  logic                  illegal_q, illegal_d;
  logic                  bus_err_q, bus_err_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [CMP_W-1:0]      op_in;
  logic [CMP_W-1:0]      op_lat;

  assign op_in  = CMP_W'(opcode);
  assign op_lat = CMP_W'(opcode_q);

  function automatic logic is_legal(input logic [CMP_W-1:0] op);
    return (op == OP_SEXT)  || (op == OP_MOV)  || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_JUMP) || (op == OP_ALU0) ||
           (op == OP_ALU1)  || (op == OP_ALU2) || (op == OP_ALU3) ||
           (op == OP_HALT);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d             = state_q;
    opcode_d            = opcode_q;
    wait_d              = '0;
    illegal_d           = illegal_q;
    bus_err_d           = bus_err_q;
    mem_req             = 1'b0;
    ir_load             = 1'b0;
    pc_enable           = 1'b0;
    write_enable_memory = 1'b0;
    write_enable_reg    = 1'b0;
    jump_enable         = 1'b0;
    finaliza_execucao   = 1'b0;
    control_op          = SRC_ALU;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        // A mem_ready that arrives in the last permitted cycle still completes
        // the request; the timeout only fires when mem_ready stays low.
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        opcode_d = opcode;
        if (op_in == OP_HALT) begin
          state_d = S_HALT;
        end else if (!is_legal(op_in)) begin
          illegal_d = 1'b1;
          if (ILLEGAL_HALTS != 0) begin
            state_d = S_HALT;
          end else begin
            pc_enable = 1'b1;
            state_d   = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (op_lat == OP_SEXT) begin
          write_enable_reg = 1'b1;
          control_op       = SRC_SEXT;
          pc_enable        = 1'b1;
        end else if (op_lat == OP_MOV) begin
          write_enable_reg = 1'b1;
          control_op       = SRC_REG2;
          pc_enable        = 1'b1;
        end else if ((op_lat == OP_ALU0) || (op_lat == OP_ALU1) ||
                     (op_lat == OP_ALU2) || (op_lat == OP_ALU3)) begin
          write_enable_reg = 1'b1;
          control_op       = SRC_ALU;
          pc_enable        = 1'b1;
        end else if (op_lat == OP_JUMP) begin
          jump_enable = 1'b1;
          pc_enable   = 1'b1;
        end else if ((op_lat == OP_LOAD) || (op_lat == OP_STORE)) begin
          state_d = S_MEM;
        end
      end

      S_MEM: begin
        mem_req             = 1'b1;
        write_enable_memory = (op_lat == OP_STORE);
        if (mem_ready) begin
          if (op_lat == OP_STORE) begin
            pc_enable = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        write_enable_reg = 1'b1;
        control_op       = SRC_MEM;
        pc_enable        = 1'b1;
        state_d          = S_FETCH;
      end

      S_HALT: begin
        finaliza_execucao = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Every PC advance retires one instruction; the count sticks at all-ones.
    count_d = count_q;
    if (pc_enable && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  assign illegal_op  = illegal_q;
  assign bus_error   = bus_err_q;
  assign instr_count = count_q;

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm -- directed, scoreboard-checked bench for control_fsm.
//
// Three instances share one stimulus stream:
//   dut      default parameters
//   dut_nop  ILLEGAL_HALTS = 0, so illegal opcodes are retired as NOPs
//   dut_sat  CNT_W = 2, so the retired-instruction counter saturates at 3
// In each step the bench drives the inputs on the falling clock edge, pushes
// the outputs it expects for that cycle into a queue, and then pops and
// compares every entry 1 ns later, away from the rising edge.

module tb_control_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] opcode;
  logic       mem_ready;

  logic d_mem_req, d_ir_load, d_pc_en, d_wem, d_wer, d_jmp, d_fin, d_ill, d_be;
  logic [1:0]  d_cop;
  logic [15:0] d_cnt;
  logic n_mem_req, n_ir_load, n_pc_en, n_wem, n_wer, n_jmp, n_fin, n_ill, n_be;
  logic [1:0]  n_cop;
  logic [15:0] n_cnt;
  logic s_mem_req, s_ir_load, s_pc_en, s_wem, s_wer, s_jmp, s_fin, s_ill, s_be;
  logic [1:0]  s_cop;
  logic [1:0]  s_cnt;

  control_fsm dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(d_mem_req), .ir_load(d_ir_load), .pc_enable(d_pc_en),
    .write_enable_memory(d_wem), .write_enable_reg(d_wer), .jump_enable(d_jmp),
    .finaliza_execucao(d_fin), .control_op(d_cop), .illegal_op(d_ill),
    .bus_error(d_be), .instr_count(d_cnt)
  );

  control_fsm #(.ILLEGAL_HALTS(0)) dut_nop (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .ir_load(n_ir_load), .pc_enable(n_pc_en),
    .write_enable_memory(n_wem), .write_enable_reg(n_wer), .jump_enable(n_jmp),
    .finaliza_execucao(n_fin), .control_op(n_cop), .illegal_op(n_ill),
    .bus_error(n_be), .instr_count(n_cnt)
  );

  control_fsm #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .ir_load(s_ir_load), .pc_enable(s_pc_en),
    .write_enable_memory(s_wem), .write_enable_reg(s_wer), .jump_enable(s_jmp),
    .finaliza_execucao(s_fin), .control_op(s_cop), .illegal_op(s_ill),
    .bus_error(s_be), .instr_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int { K_D_OUT, K_D_CNT, K_N_OUT, K_N_CNT, K_S_CNT } kind_e;

  typedef struct {
    string       tag;
    kind_e       kind;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Packed output word: {mem_req, ir_load, pc_enable, wem, wer, jump, fin,
  // control_op[1:0], illegal_op, bus_error}
  function automatic logic [15:0] pk(input logic mr, input logic il,
                                     input logic pc, input logic wem,
                                     input logic wer, input logic jmp,
                                     input logic fin, input logic [1:0] cop,
                                     input logic ill, input logic be);
    return {5'b0, mr, il, pc, wem, wer, jmp, fin, cop, ill, be};
  endfunction

  function automatic logic [15:0] obs(input kind_e k);
    case (k)
      K_D_OUT: return pk(d_mem_req, d_ir_load, d_pc_en, d_wem, d_wer, d_jmp,
                         d_fin, d_cop, d_ill, d_be);
      K_D_CNT: return d_cnt;
      K_N_OUT: return pk(n_mem_req, n_ir_load, n_pc_en, n_wem, n_wer, n_jmp,
                         n_fin, n_cop, n_ill, n_be);
      K_N_CNT: return n_cnt;
      default: return 16'(s_cnt);
    endcase
  endfunction

  task automatic push(input string tag, input kind_e k, input logic [15:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic eo(input string tag, input logic [15:0] v);
    push(tag, K_D_OUT, v);
  endtask

  task automatic ec(input string tag, input logic [15:0] v);
    push(tag, K_D_CNT, v);
  endtask

  // Drive one cycle of inputs on the falling edge, then wait 1 ns so the
  // combinational outputs settle before they are compared.
  task automatic cyc(input logic s, input logic [7:0] op, input logic mr,
                     input logic r);
    @(negedge clk);
    start     = s;
    opcode    = op;
    mem_ready = mr;
    rst       = r;
    #1;
  endtask

  task automatic chk();
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.kind);
      n_cmp++;
      assert (got === e.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, got, e.exp);
      end
    end
  endtask

  // FETCH completing immediately, then DECODE of op with all strobes low.
  task automatic fetch_decode(input logic [7:0] op);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("fetch_ready", pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    chk();
    cyc(1'b0, op, 1'b0, 1'b0);
    eo("decode", pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    chk();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] alu_ops [3];
    alu_ops = '{8'h0A, 8'h0B, 8'h0C};

    rst = 1'b1; start = 1'b0; opcode = 8'h00; mem_ready = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset state: IDLE, everything low. mem_ready is ignored in IDLE.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("reset_outs", 16'h0000);
    ec("reset_cnt", 16'd0);
    push("reset_nop_cnt", K_N_CNT, 16'd0);
    push("reset_sat_cnt", K_S_CNT, 16'd0);
    chk();

    // ALU op 09 with mem_ready high throughout: FETCH, DECODE, EXEC.
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    eo("idle_start", 16'h0000);
    chk();
    fetch_decode(8'h09);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("exec_09", pk(0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    ec("exec_09_cnt_before", 16'd0);
    chk();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("fetch_wait", pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    ec("cnt_after_09", 16'd1);
    chk();

    // Load 02: mem_ready is ignored in EXEC; MEM waits 3 cycles, completes on the 4th.
    fetch_decode(8'h02);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("exec_load", 16'h0000);
    chk();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      eo("mem_load_wait", pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
      chk();
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("mem_load_ready", pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    chk();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("wb_load", pk(0, 0, 1, 0, 1, 0, 0, 2'b11, 0, 0));
    chk();

    // Jump 05.
    fetch_decode(8'h05);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("exec_jump", pk(0, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0));
    ec("cnt_before_jump", 16'd2);
    chk();

    // Sign-extend 00 and move 01.
    fetch_decode(8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("exec_sext", pk(0, 0, 1, 0, 1, 0, 0, 2'b01, 0, 0));
    push("sat_cnt_3", K_S_CNT, 16'd3);
    chk();
    fetch_decode(8'h01);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("exec_mov", pk(0, 0, 1, 0, 1, 0, 0, 2'b10, 0, 0));
    ec("cnt_before_mov", 16'd4);
    chk();

    // Remaining ALU ops.
    for (int i = 0; i < 3; i++) begin
      fetch_decode(alu_ops[i]);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      eo("exec_alu", pk(0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0));
      chk();
    end

    // Store 03: mem_ready arrives in the 15th (last) MEM cycle and wins.
    fetch_decode(8'h03);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("exec_store", 16'h0000);
    ec("cnt_after_alus", 16'd8);
    push("sat_cnt_held", K_S_CNT, 16'd3);
    chk();
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      eo("mem_store_wait", pk(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
      chk();
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("mem_store_last_ready", pk(1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    chk();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("fetch_after_store", pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    ec("cnt_after_store", 16'd9);
    chk();

    // Store 03 with mem_ready never arriving: 15 MEM cycles, then HALT with bus_error.
    fetch_decode(8'h03);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("exec_store2", 16'h0000);
    chk();
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      eo("mem_store_timeout_wait", pk(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
      chk();
    end
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    eo("halt_bus_error", pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1));
    ec("cnt_after_timeout", 16'd9);
    push("sat_cnt_final", K_S_CNT, 16'd3);
    chk();
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    eo("halt_ignores_start", pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1));
    chk();

    // Illegal opcode 0x77: the default instance halts; dut_nop retires it as a NOP.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    eo("idle_after_rst", 16'h0000);
    ec("cnt_after_rst", 16'd0);
    chk();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("fetch_ill", pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    chk();
    cyc(1'b0, 8'h77, 1'b0, 1'b0);
    eo("decode_ill_halts", 16'h0000);
    push("decode_ill_nop", K_N_OUT, pk(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
    chk();
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    eo("halt_illegal", pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0));
    ec("cnt_illegal_halt", 16'd0);
    push("nop_fetch_illegal", K_N_OUT, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    push("nop_cnt", K_N_CNT, 16'd1);
    chk();

    // HALT opcode FF: not counted; start is ignored; rst returns to IDLE.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    eo("idle_flags_cleared", 16'h0000);
    push("nop_idle_flags_cleared", K_N_OUT, 16'h0000);
    chk();
    fetch_decode(8'hFF);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    eo("halt_ff", pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
    ec("cnt_halt_ff", 16'd0);
    chk();
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    eo("halt_ff_start", pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
    chk();
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    eo("idle_after_halt_rst", 16'h0000);
    chk();

    // Reset in the middle of MEM, with start and mem_ready also high, wins.
    fetch_decode(8'h09);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("exec_09_again", pk(0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    chk();
    fetch_decode(8'h03);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    eo("mem_before_rst", pk(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    ec("cnt_before_mid_rst", 16'd1);
    chk();
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    eo("mem_with_rst", pk(1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    chk();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("idle_after_mid_rst", 16'h0000);
    ec("cnt_after_mid_rst", 16'd0);
    chk();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    eo("idle_stays", 16'h0000);
    chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
